// File: rtl/ex_muldiv_seq_if.sv
// Handshake/operand bundle between the execute stage and the iterative
// multiply/divide sequencer. The core side is the master, the sequencer the slave.
interface ex_muldiv_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic                  flush_i;
  logic [2:0]            funct3_i;
  logic [DATA_WIDTH-1:0] operand1_i;
  logic [DATA_WIDTH-1:0] operand2_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;

  modport master (
    output start_i, flush_i, funct3_i, operand1_i, operand2_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, flush_i, funct3_i, operand1_i, operand2_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer. Radix-2 shift-add multiply and
// restoring divide share one hi/lo register pair: for multiply hi accumulates
// the upper product and lo shifts out the multiplier; for divide hi is the
// partial remainder and lo shifts the dividend out / quotient bits in.
// Operands are converted to magnitudes on launch; the sign is reapplied on
// the final step. Divide-by-zero and signed overflow use a precomputed result.
module ex_muldiv_seq #(
  parameter int DATA_WIDTH   = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ex_muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam int W  = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [2:0]      op;
  logic [W-1:0]    hi, lo, mcand, spec_res, result;
  logic            neg, spec;

  logic            launch, launch_fast, finish;
  logic            is_div, op1_signed, op2_signed, a_neg, b_neg;
  logic [W-1:0]    mag1, mag2, spec_value;
  logic            div_zero, div_ovf, special;
  logic [W:0]      mul_sum, div_shift, div_diff;
  logic [W-1:0]    hi_step, lo_step;
  logic [2*W-1:0]  product, product_signed;
  logic [W-1:0]    div_val, div_signed, final_res;

  // Decode the incoming op: signedness, magnitudes, special cases, result sign.
  always_comb begin
    is_div     = bus.funct3_i[2];
    op1_signed = is_div ? ~bus.funct3_i[0]
                        : (bus.funct3_i[1:0] == 2'b01) || (bus.funct3_i[1:0] == 2'b10);
    op2_signed = is_div ? ~bus.funct3_i[0] : (bus.funct3_i[1:0] == 2'b01);
    a_neg      = op1_signed & bus.operand1_i[W-1];
    b_neg      = op2_signed & bus.operand2_i[W-1];
    mag1       = a_neg ? (~bus.operand1_i + {{(W-1){1'b0}}, 1'b1}) : bus.operand1_i;
    mag2       = b_neg ? (~bus.operand2_i + {{(W-1){1'b0}}, 1'b1}) : bus.operand2_i;
    div_zero   = is_div && (bus.operand2_i == {W{1'b0}});
    div_ovf    = is_div && !bus.funct3_i[0]
                 && (bus.operand1_i == {1'b1, {(W-1){1'b0}}})
                 && (bus.operand2_i == {W{1'b1}});
    special    = div_zero || div_ovf;
    if (div_zero) begin
      spec_value = bus.funct3_i[1] ? bus.operand1_i : {W{1'b1}};
    end else begin
      spec_value = bus.funct3_i[1] ? {W{1'b0}} : {1'b1, {(W-1){1'b0}}};
    end
  end

  // One iteration step for the current op, plus sign-corrected final result.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    div_shift = {hi, lo[W-1]};
    div_diff  = div_shift - {1'b0, mcand};
    if (!op[2]) begin
      hi_step = mul_sum[W:1];
      lo_step = {mul_sum[0], lo[W-1:1]};
    end else if (!div_diff[W]) begin
      hi_step = div_diff[W-1:0];
      lo_step = {lo[W-2:0], 1'b1};
    end else begin
      hi_step = div_shift[W-1:0];
      lo_step = {lo[W-2:0], 1'b0};
    end
    product        = {hi_step, lo_step};
    product_signed = neg ? (~product + {{(2*W-1){1'b0}}, 1'b1}) : product;
    div_val        = op[1] ? hi_step : lo_step;
    div_signed     = neg ? (~div_val + {{(W-1){1'b0}}, 1'b1}) : div_val;
    if (spec) begin
      final_res = spec_res;
    end else if (op[2]) begin
      final_res = div_signed;
    end else if (op == 3'b000) begin
      final_res = product_signed[W-1:0];
    end else begin
      final_res = product_signed[2*W-1:W];
    end
  end

  // Next-state and launch/finish control.
  always_comb begin
    state_nxt   = state;
    launch      = 1'b0;
    launch_fast = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start_i && !bus.flush_i) begin
          launch      = 1'b1;
          launch_fast = special && FAST_SPECIAL;
          state_nxt   = launch_fast ? DONE : CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (bus.flush_i) begin
          state_nxt = IDLE;
        end else if (count == {CW{1'b0}}) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = CALC;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand latch, iteration registers and result register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count    <= {CW{1'b0}};
      op       <= 3'b000;
      hi       <= {W{1'b0}};
      lo       <= {W{1'b0}};
      mcand    <= {W{1'b0}};
      spec_res <= {W{1'b0}};
      neg      <= 1'b0;
      spec     <= 1'b0;
      result   <= {W{1'b0}};
    end else if (launch) begin
      count    <= CW'(W - 1);
      op       <= bus.funct3_i;
      hi       <= {W{1'b0}};
      lo       <= is_div ? mag1 : mag2;
      mcand    <= is_div ? mag2 : mag1;
      spec_res <= spec_value;
      spec     <= special;
      neg      <= (is_div && bus.funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
      if (launch_fast) begin
        result <= spec_value;
      end
    end else if (state == CALC && !bus.flush_i) begin
      hi    <= hi_step;
      lo    <= lo_step;
      count <= count - CW'(1);
      if (finish) begin
        result <= final_res;
      end
    end
  end

  assign bus.busy_o   = (state == CALC);
  assign bus.done_o   = (state == DONE);
  assign bus.result_o = result;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: table of ops with expected result and
// latency, then hand-written flush, reset, start/flush and back-to-back cases.
module tb_ex_muldiv_seq;
  logic clk;
  logic rst;
  int   total;
  int   passed;

  ex_muldiv_seq_if #(.DATA_WIDTH(32)) bus ();

  ex_muldiv_seq #(.DATA_WIDTH(32), .FAST_SPECIAL(1'b1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.start_i    = 1'b1;
    bus.funct3_i   = f3;
    bus.operand1_i = a;
    bus.operand2_i = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [31:0] res, output int busy_cnt);
    lat      = 99;
    res      = 32'h0;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done_o) begin
        lat = k;
        res = bus.result_o;
        break;
      end
      if (bus.busy_o) busy_cnt++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          lat;
    int          bcnt;
    logic [31:0] res;
    logic        saw_done;

    total = 0;
    passed = 0;
    tbl[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32};
    tbl[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32};
    tbl[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32};
    tbl[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32};
    tbl[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32};
    tbl[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32};
    tbl[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       32};
    tbl[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        32};
    tbl[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0};
    tbl[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        0};
    tbl[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
    tbl[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0};
    tbl[12] = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 32};
    tbl[13] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32};
    tbl[14] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        32};
    tbl[15] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32};
    tbl[16] = '{3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 0};
    tbl[17] = '{3'b111, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32};

    bus.start_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.funct3_i   = 3'b000;
    bus.operand1_i = 32'h0;
    bus.operand2_i = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset_busy",   {31'h0, bus.busy_o}, 32'h0);
    check("reset_done",   {31'h0, bus.done_o}, 32'h0);
    check("reset_result", bus.result_o,        32'h0);

    // table-driven ops: result, busy duration, latency, single-cycle done pulse
    for (int i = 0; i < 18; i++) begin
      launch(tbl[i].f3, tbl[i].a, tbl[i].b);
      wait_done(lat, res, bcnt);
      check($sformatf("vec%0d_result", i), res, tbl[i].exp);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, tbl[i].lat);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), {31'h0, bus.done_o}, 32'h0);
      check($sformatf("vec%0d_result_hold", i), bus.result_o, tbl[i].exp);
    end

    // flush at CALC cycle 10: busy drops, no done, result keeps prior value
    launch(3'b000, 32'd3, 32'd5);
    repeat (10) begin @(posedge clk); #1; end
    check("flush_busy_before", {31'h0, bus.busy_o}, 32'h1);
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    check("flush_busy_after", {31'h0, bus.busy_o}, 32'h0);
    check("flush_result", bus.result_o, tbl[17].exp);
    saw_done = bus.done_o;
    repeat (35) begin
      @(posedge clk); #1;
      saw_done = saw_done | bus.done_o;
    end
    check("flush_no_done", {31'h0, saw_done}, 32'h0);

    // simultaneous start and flush: nothing launched
    bus.flush_i = 1'b1;
    launch(3'b101, 32'd5, 32'd0);
    bus.flush_i = 1'b0;
    check("startflush_busy", {31'h0, bus.busy_o}, 32'h0);
    check("startflush_done", {31'h0, bus.done_o}, 32'h0);

    // reset mid-CALC clears everything
    launch(3'b101, 32'd100, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset_busy",   {31'h0, bus.busy_o}, 32'h0);
    check("midreset_done",   {31'h0, bus.done_o}, 32'h0);
    check("midreset_result", bus.result_o,        32'h0);

    // back-to-back: new start held during DONE
    launch(3'b101, 32'd100, 32'd7);
    wait_done(lat, res, bcnt);
    check("b2b_first_result", res, 32'd14);
    check("b2b_first_latency", lat, 32);
    launch(3'b000, 32'd7, 32'hFFFFFFFD);
    check("b2b_done_single", {31'h0, bus.done_o}, 32'h0);
    check("b2b_busy_next",   {31'h0, bus.busy_o}, 32'h1);
    wait_done(lat, res, bcnt);
    check("b2b_second_result", res, 32'hFFFFFFEB);
    check("b2b_second_latency", lat, 32);

    // flush during DONE blocks a same-cycle start but keeps the result
    launch(3'b111, 32'd100, 32'd7);
    wait_done(lat, res, bcnt);
    check("doneflush_result", res, 32'd2);
    bus.flush_i = 1'b1;
    launch(3'b000, 32'd2, 32'd2);
    bus.flush_i = 1'b0;
    check("doneflush_busy", {31'h0, bus.busy_o}, 32'h0);
    check("doneflush_hold", bus.result_o, 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
